// File: rtl/lvds_rx_word_align.sv
// ---------------------------------------------------------------------------
// lvds_rx_word_align
//
// Word aligner placed directly after an LVDS deserialiser. It pulses the
// receiver's bitslip input until a known training word is seen for a run of
// consecutive cycles. Once aligned, it forwards payload words with a valid
// flag. If no rotation matches within the slip budget, it flags an error.
//
// Ports
//   clk           receiver output clock, rising edge
//   rst           asynchronous active-high reset
//   rx_locked     receiver PLL lock (asynchronous; synchronised internally)
//   rx_data[7:0]  deserialised word from the receiver
//   retrain       single-cycle request to restart alignment
//   rx_data_align bitslip request to the receiver
//   aligned       high while locked onto the training pattern
//   align_err     high after the slip budget was exhausted
//   slip_cnt[4:0] slips issued in the current attempt
//   data_out[7:0] registered payload word
//   data_valid    data_out carries payload
// ---------------------------------------------------------------------------
module lvds_rx_word_align #(
    parameter logic [7:0]  TRAIN_WORD  = 8'h5C,
    parameter int unsigned MATCH_COUNT = 16,
    parameter int unsigned ALIGN_PULSE = 2,
    parameter int unsigned SLIP_WAIT   = 4,
    parameter int unsigned MAX_SLIPS   = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_locked,
    input  logic [7:0] rx_data,
    input  logic       retrain,
    output logic       rx_data_align,
    output logic       aligned,
    output logic       align_err,
    output logic [4:0] slip_cnt,
    output logic [7:0] data_out,
    output logic       data_valid
);

    localparam int unsigned MATCH_W = 8;
    localparam int unsigned TIMER_W = 4;
    localparam int unsigned SLIP_W  = 5;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CHECK  = 3'd1;
    localparam logic [2:0] S_SLIP   = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_LOCKED = 3'd4;
    localparam logic [2:0] S_FAIL   = 3'd5;

    localparam logic [MATCH_W-1:0] MATCH_TARGET = MATCH_W'(MATCH_COUNT);
    localparam logic [TIMER_W-1:0] PULSE_LAST   = TIMER_W'(ALIGN_PULSE - 1);
    localparam logic [TIMER_W-1:0] WAIT_LAST    = TIMER_W'(SLIP_WAIT - 1);
    localparam logic [SLIP_W-1:0]  SLIP_LIMIT   = SLIP_W'(MAX_SLIPS);
    localparam logic [SLIP_W-1:0]  SLIP_SAT     = '1;

    logic                lock_meta;
    logic                lock_s;
    logic [2:0]          state;
    logic [2:0]          state_next;
    logic [MATCH_W-1:0]  match_cnt;
    logic [MATCH_W-1:0]  match_next;
    logic [MATCH_W-1:0]  match_inc;
    logic [TIMER_W-1:0]  timer;
    logic [TIMER_W-1:0]  timer_next;
    logic [SLIP_W-1:0]   slip_next;

    // Two-flop synchroniser for the receiver lock flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= rx_locked;
            lock_s    <= lock_meta;
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            match_cnt     <= '0;
            timer         <= '0;
            slip_cnt      <= '0;
            rx_data_align <= 1'b0;
            aligned       <= 1'b0;
            align_err     <= 1'b0;
            data_valid    <= 1'b0;
            data_out      <= 8'h00;
        end else begin
            state         <= state_next;
            match_cnt     <= match_next;
            timer         <= timer_next;
            slip_cnt      <= slip_next;
            rx_data_align <= (state_next == S_SLIP);
            aligned       <= (state_next == S_LOCKED);
            align_err     <= (state_next == S_FAIL);
            data_valid    <= (state_next == S_LOCKED);
            // Capture on every edge that leaves the block in LOCKED, so the
            // word under data_valid is always a freshly registered one.
            if (state_next == S_LOCKED) begin
                data_out <= rx_data;
            end
        end
    end

    assign match_inc = match_cnt + 1'b1;

    // Next-state and counter logic
    always_comb begin
        state_next = state;
        match_next = match_cnt;
        timer_next = timer;
        slip_next  = slip_cnt;

        case (state)
            S_IDLE: begin
                if (lock_s) begin
                    state_next = S_CHECK;
                end
            end

            S_CHECK: begin
                if (rx_data == TRAIN_WORD) begin
                    match_next = match_inc;
                    if (match_inc == MATCH_TARGET) begin
                        state_next = S_LOCKED;
                    end
                end else begin
                    // Any miss restarts the run count and costs one slip.
                    match_next = '0;
                    if (slip_cnt == SLIP_LIMIT) begin
                        state_next = S_FAIL;
                    end else begin
                        state_next = S_SLIP;
                        if (slip_cnt != SLIP_SAT) begin
                            slip_next = slip_cnt + 1'b1;
                        end
                    end
                end
            end

            S_SLIP: begin
                if (timer == PULSE_LAST) begin
                    state_next = S_WAIT;
                end else begin
                    timer_next = timer + 1'b1;
                end
            end

            S_WAIT: begin
                if (timer == WAIT_LAST) begin
                    state_next = S_CHECK;
                end else begin
                    timer_next = timer + 1'b1;
                end
            end

            S_LOCKED: begin
                state_next = S_LOCKED;
            end

            S_FAIL: begin
                state_next = S_FAIL;
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase

        // Lock loss or retrain abandons any active state; retrain in IDLE is a no-op.
        if ((state != S_IDLE) && (!lock_s || retrain)) begin
            state_next = S_IDLE;
        end

        // Counters restart on every state entry so they never wrap.
        if (state_next != state) begin
            match_next = '0;
            timer_next = '0;
        end

        // IDLE presents a cleared slip count for the next attempt.
        if (state_next == S_IDLE) begin
            slip_next = '0;
        end
    end

endmodule

// File: tb/tb_lvds_rx_word_align.sv
// ---------------------------------------------------------------------------
// tb_lvds_rx_word_align
//
// Bench for lvds_rx_word_align. A receiver model rotates its word right by
// one bit on every rising edge of rx_data_align. Alignment scenarios come
// from a vector table; payload forwarding uses a scoreboard queue; reset,
// retrain and lock-loss corners are hand-written sequences.
// ---------------------------------------------------------------------------
module tb_lvds_rx_word_align;

    localparam logic [7:0]  TRAIN_WORD  = 8'h5C;
    localparam int unsigned MATCH_COUNT = 16;
    localparam int unsigned ALIGN_PULSE = 2;
    localparam int unsigned SLIP_WAIT   = 4;
    localparam int unsigned MAX_SLIPS   = 16;
    localparam int          SYNC_LAT    = 2;
    localparam int          SLIP_COST   = 1 + ALIGN_PULSE + SLIP_WAIT;

    logic       clk;
    logic       rst;
    logic       rx_locked;
    logic [7:0] rx_data;
    logic       retrain;
    logic       rx_data_align;
    logic       aligned;
    logic       align_err;
    logic [4:0] slip_cnt;
    logic [7:0] data_out;
    logic       data_valid;

    int checks = 0;
    int errors = 0;

    logic [7:0] word;
    logic       align_prev;
    logic [7:0] sb[$];

    typedef struct {
        logic [7:0] pattern;
        int         exp_slips;
        bit         exp_fail;
    } vec_t;

    lvds_rx_word_align #(
        .TRAIN_WORD (TRAIN_WORD),
        .MATCH_COUNT(MATCH_COUNT),
        .ALIGN_PULSE(ALIGN_PULSE),
        .SLIP_WAIT  (SLIP_WAIT),
        .MAX_SLIPS  (MAX_SLIPS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_locked    (rx_locked),
        .rx_data      (rx_data),
        .retrain      (retrain),
        .rx_data_align(rx_data_align),
        .aligned      (aligned),
        .align_err    (align_err),
        .slip_cnt     (slip_cnt),
        .data_out     (data_out),
        .data_valid   (data_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] rotr(input logic [7:0] w);
        return {w[0], w[7:1]};
    endfunction

    // Right rotations needed to reach the training word, or -1 if none.
    function automatic int slips_needed(input logic [7:0] w);
        logic [7:0] t;
        t = w;
        for (int k = 0; k < 8; k++) begin
            if (t == TRAIN_WORD) return k;
            t = rotr(t);
        end
        return -1;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    // One clock: sample point is #1 after the edge, then the receiver model reacts.
    task automatic step();
        @(posedge clk);
        #1;
        if (rx_data_align && !align_prev) word = rotr(word);
        align_prev = rx_data_align;
        rx_data = word;
    endtask

    task automatic do_reset(input logic [7:0] w);
        rst        = 1'b1;
        rx_locked  = 1'b0;
        retrain    = 1'b0;
        word       = w;
        rx_data    = w;
        align_prev = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Raise lock and run until aligned, failed, or the budget runs out.
    task automatic run_align(input int budget, output int cyc, output int slips,
                             output int bad, output bit ok, output bit failed);
        int  hi;
        int  lo;
        bit  seen_pulse;
        hi = 0; lo = 0; seen_pulse = 0;
        cyc = 0; slips = 0; bad = 0; ok = 0; failed = 0;
        rx_locked = 1'b1;
        while (cyc < budget && !ok && !failed) begin
            step();
            cyc++;
            if (rx_data_align) begin
                if (hi == 0) begin
                    slips++;
                    if (seen_pulse && lo != SLIP_WAIT + 1) bad++;
                end
                hi++;
                lo = 0;
            end else begin
                if (hi != 0) begin
                    if (hi != ALIGN_PULSE) bad++;
                    seen_pulse = 1;
                end
                hi = 0;
                lo++;
            end
            if (aligned) ok = 1;
            if (align_err) failed = 1;
        end
    endtask

    initial begin
        vec_t       vecs[6];
        int         cyc;
        int         slips;
        int         bad;
        bit         ok;
        bit         failed;
        int         exp_cyc;
        int         n;
        logic [7:0] payload[8];
        logic [7:0] exp_word;

        vecs[0] = '{8'h5C, 0,  1'b0};
        vecs[1] = '{8'hE2, 3,  1'b0};
        vecs[2] = '{8'hB8, 1,  1'b0};
        vecs[3] = '{8'h2E, 7,  1'b0};
        vecs[4] = '{8'hFF, 16, 1'b1};
        vecs[5] = '{8'h00, 16, 1'b1};

        // Reset values
        rst = 1'b1; rx_locked = 1'b0; retrain = 1'b0; rx_data = 8'h00;
        word = 8'h00; align_prev = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset rx_data_align", 32'(rx_data_align), 32'd0);
        check("reset aligned",       32'(aligned),       32'd0);
        check("reset align_err",     32'(align_err),     32'd0);
        check("reset slip_cnt",      32'(slip_cnt),      32'd0);
        check("reset data_out",      32'(data_out),      32'd0);
        check("reset data_valid",    32'(data_valid),    32'd0);

        // Table-driven alignment scenarios
        foreach (vecs[i]) begin
            do_reset(vecs[i].pattern);
            run_align(400, cyc, slips, bad, ok, failed);
            exp_cyc = vecs[i].exp_fail
                    ? SYNC_LAT + 1 + vecs[i].exp_slips * SLIP_COST + 1
                    : SYNC_LAT + 1 + vecs[i].exp_slips * SLIP_COST + MATCH_COUNT;
            check($sformatf("vec%0d outcome", i), {30'd0, failed, ok},
                  vecs[i].exp_fail ? 32'd2 : 32'd1);
            check($sformatf("vec%0d cycles", i), 32'(cyc), 32'(exp_cyc));
            check($sformatf("vec%0d slips seen", i), 32'(slips), 32'(vecs[i].exp_slips));
            check($sformatf("vec%0d slip_cnt", i), 32'(slip_cnt), 32'(vecs[i].exp_slips));
            check($sformatf("vec%0d pulse shape", i), 32'(bad), 32'd0);
            check($sformatf("vec%0d data_valid", i), 32'(data_valid), vecs[i].exp_fail ? 32'd0 : 32'd1);
            check($sformatf("vec%0d rx_data_align", i), 32'(rx_data_align), 32'd0);
        end

        // Failed block: retrain goes to IDLE, then CHECK, then slips again
        retrain = 1'b1;
        step();
        retrain = 1'b0;
        check("retrain clears align_err", 32'(align_err), 32'd0);
        check("retrain aligned low",      32'(aligned),   32'd0);
        step();
        check("retrain check no slip yet", 32'(rx_data_align), 32'd0);
        step();
        check("retrain first slip", 32'(rx_data_align), 32'd1);
        check("retrain slip_cnt",   32'(slip_cnt),      32'd1);

        // Payload forwarding through a scoreboard
        do_reset(TRAIN_WORD);
        run_align(400, cyc, slips, bad, ok, failed);
        check("payload lock", 32'(ok), 32'd1);
        payload[0] = 8'h01; payload[1] = 8'h02; payload[2] = 8'h03; payload[3] = 8'hA5;
        for (int i = 4; i < 8; i++) payload[i] = 8'($urandom_range(0, 255));
        foreach (payload[i]) begin
            word    = payload[i];
            rx_data = payload[i];
            sb.push_back(payload[i]);
            step();
            if (data_valid && sb.size() > 0) begin
                exp_word = sb.pop_front();
                check($sformatf("payload %0d data_out", i), 32'(data_out), 32'(exp_word));
            end else begin
                check($sformatf("payload %0d data_valid", i), 32'(data_valid), 32'd1);
            end
        end
        check("scoreboard drained", 32'(sb.size()), 32'd0);

        // Lock loss: still aligned through the synchroniser, gone on the third edge
        rx_locked = 1'b0;
        step();
        step();
        check("lock drop aligned after 2", 32'(aligned), 32'd1);
        step();
        check("lock drop aligned after 3",    32'(aligned),    32'd0);
        check("lock drop data_valid after 3", 32'(data_valid), 32'd0);

        // Reset asserted mid slip pulse
        do_reset(8'hE2);
        rx_locked = 1'b1;
        n = 0;
        while (!rx_data_align && n < 50) begin
            step();
            n++;
        end
        check("reached slip pulse", 32'(rx_data_align), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async rst rx_data_align", 32'(rx_data_align), 32'd0);
        check("async rst slip_cnt",      32'(slip_cnt),      32'd0);
        check("async rst aligned",       32'(aligned),       32'd0);
        check("async rst data_valid",    32'(data_valid),    32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        align_prev = 1'b0;
        check("post rst slip_cnt", 32'(slip_cnt), 32'd0);
        n = slips_needed(word);
        run_align(400, cyc, slips, bad, ok, failed);
        check("post rst aligned",  32'(ok),       32'd1);
        check("post rst slips",    32'(slips),    32'(n));
        check("post rst slip_cnt", 32'(slip_cnt), 32'(n));
        check("post rst cycles",   32'(cyc),      32'(SYNC_LAT + 1 + n * SLIP_COST + MATCH_COUNT));

        // Retrain on the final matching word wins over alignment
        do_reset(TRAIN_WORD);
        rx_locked = 1'b1;
        repeat (SYNC_LAT + MATCH_COUNT) step();
        retrain = 1'b1;
        step();
        retrain = 1'b0;
        check("retrain vs match aligned",    32'(aligned),    32'd0);
        check("retrain vs match data_valid", 32'(data_valid), 32'd0);
        repeat (MATCH_COUNT) step();
        check("realign not early", 32'(aligned), 32'd0);
        step();
        check("realign on time", 32'(aligned), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
